testdrive_axi4_read_arbiter: RTL and testbench
==============================================

// Module: testdrive_axi4_read_arbiter
// PURPOSE
//  Shares one AXI4 read channel (AR/R) of the system-sim AXI4 slave model among C_PORTS simple read requesters.
//  Round-robin grant on the address phase; ARID carries the port index; R beats are routed back by RID.
//  Per-port outstanding-burst limit prevents one requester from starving the others. Sits between DUT-side engines and the BFM.
// PARAMETERS
//  C_PORTS            4    number of requesters (2..16)
//  C_ADDR_WIDTH       32   AXI address width
//  C_DATA_WIDTH       128  AXI data width (8..1024, power of 2)
//  C_THREAD_ID_WIDTH  4    ARID/RID width; must be >= $clog2(C_PORTS) (elaboration $error otherwise)
//  C_MAX_OUTSTANDING  4    max in-flight bursts per port (1..15)
// PORTS
//  CLK        in   1                  clock
//  nRST       in   1                  reset (active low)
//  REQ_VALID  in   C_PORTS            per-port read request valid
//  REQ_READY  out  C_PORTS            per-port request accepted
//  REQ_ADDR   in   C_PORTS*ADDR       per-port start address, port p at [p*ADDR +: ADDR]
//  REQ_LEN    in   C_PORTS*8          per-port AxLEN (beats-1), port p at [p*8 +: 8]
//  RSP_VALID  out  C_PORTS            per-port read beat valid (one-hot or zero)
//  RSP_READY  in   C_PORTS            per-port beat accept
//  RSP_DATA   out  C_DATA_WIDTH       shared beat data (= RDATA)
//  RSP_RESP   out  2                  shared beat response (= RRESP)
//  RSP_LAST   out  1                  shared last-beat flag (= RLAST)
//  ERR        out  1                  sticky: R beat with RID >= C_PORTS or with zero outstanding count
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  AXI4 read address (widths per AXI4, ARLEN 8)
//  ARREADY    in   1
//  RID/RDATA/RRESP/RLAST/RVALID  in  AXI4 read data
//  RREADY     out  1
// BEHAVIOUR
//  Clocking: single clock CLK; nRST asynchronous, active low; all state cleared immediately on assertion.
//  Reset values: ARVALID=0, ARID/ARADDR/ARLEN=0, REQ_READY=0, ERR=0, RR pointer=0, all counters=0.
//  ARSIZE constant = $clog2(C_DATA_WIDTH/8); ARBURST constant = 2'b01 (INCR).
//  FSM IDLE/ADDR:
//   IDLE: eligible[p] = REQ_VALID[p] && cnt[p] < C_MAX_OUTSTANDING.
//     Winner g = first eligible at or after pointer (wrap to 0).
//     REQ_READY = onehot(g) combinationally, 0 if none.
//     On handshake: ARID<=g, ARADDR/ARLEN<=port g fields, ARVALID<=1, ->ADDR.
//   ADDR: REQ_READY=0. ARVALID and payload held stable until ARREADY.
//     On ARREADY: ARVALID<=0, pointer<=(g+1)%C_PORTS, cnt[g]++, ->IDLE.
//  Latency: request handshake cycle N -> ARVALID at N+1. Peak rate one AR per 2 cycles.
//  Return path (combinational, no storage): i = RID.
//   If i<C_PORTS: RSP_VALID=onehot(i)&RVALID; RREADY=RSP_READY[i].
//   Else: RREADY=1 (beat dropped), ERR<=1 on RVALID.
//   RSP_DATA/RESP/LAST pass RDATA/RRESP/RLAST straight through.
//  Counter rules (cnt width 4 bits):
//   decrement cnt[RID] on RVALID&RREADY&RLAST.
//   Same-port AR accept and last beat in the same cycle -> cnt unchanged.
//   Decrement at cnt==0 -> no underflow, ERR<=1.
//  Ordering: bursts of one port return in AR order (same ID); interleaving across ports is allowed and passes through.
//  nRST mid-burst: ARVALID drops asynchronously, in-flight bursts are forgotten. Bench/BFM must be reset together.
// STRUCTURE
//  Package testdrive_axi4_pkg: burst_t (FIXED/INCR/WRAP), resp_t (OKAY/EXOKAY/SLVERR/DECERR), AXI4_LEN_WIDTH=8.
//  Sub-module testdrive_rr_arbiter #(N): req[N], pointer in, onehot grant + index out; purely combinational.
//  Top: FSM, AR register stage, counter array, RID demux, ERR flag.
// TESTING
//  1. Single port 0, ADDR=0x1000, LEN=3 -> one AR (ARID=0, ARSIZE=4, ARBURST=1), 4 beats on RSP_VALID[0], RSP_LAST on 4th, cnt back to 0.
//  2. All 4 ports request every cycle, ARREADY=1 -> grant order 0,1,2,3,0...; ARVALID every other cycle.
//  3. Port 1 issues 4 ARs, R withheld -> 5th request stalls (REQ_READY[1]=0) while port 2 is still granted; first RLAST to port 1 re-enables it.
//  4. ARREADY held low 10 cycles -> ARVALID/ARADDR/ARLEN/ARID stable throughout; REQ_READY=0 throughout.
//  5. RID=5 with C_PORTS=4 -> RREADY=1, no RSP_VALID, ERR=1 next cycle and stays until nRST.
//  6. nRST low while in ADDR with cnt[0]=2 -> ARVALID=0 immediately; after release, pointer=0, all cnt=0, ERR=0.

Source files
------------

// File: rtl/testdrive_axi4_read_arbiter_pkg.sv
// Shared encodings for the AXI4 read arbiter: burst and response codes, FSM states
// and the beat-size helper.
package testdrive_axi4_pkg;

  localparam int AXI4_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ADDR = 1'b1
  } arb_state_t;

  // AxSIZE encoding for a full-width beat of the given data bus width
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/testdrive_axi4_read_arbiter_if.sv
// Bus bundles for the read arbiter: the shared AXI4 AR/R channel and the
// flattened per-port requester side.
interface testdrive_axi4_read_arbiter_if #(
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_THREAD_ID_WIDTH = 4
);
  import testdrive_axi4_pkg::*;

  logic [C_THREAD_ID_WIDTH-1:0] arid;
  logic [C_ADDR_WIDTH-1:0]      araddr;
  logic [AXI4_LEN_WIDTH-1:0]    arlen;
  logic [2:0]                   arsize;
  logic [1:0]                   arburst;
  logic                         arvalid;
  logic                         arready;
  logic [C_THREAD_ID_WIDTH-1:0] rid;
  logic [C_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                   rresp;
  logic                         rlast;
  logic                         rvalid;
  logic                         rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

interface testdrive_axi4_read_req_if #(
  parameter int C_PORTS      = 4,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 128
);
  logic [C_PORTS-1:0]              req_valid;
  logic [C_PORTS-1:0]              req_ready;
  logic [C_PORTS*C_ADDR_WIDTH-1:0] req_addr;
  logic [C_PORTS*8-1:0]            req_len;
  logic [C_PORTS-1:0]              rsp_valid;
  logic [C_PORTS-1:0]              rsp_ready;
  logic [C_DATA_WIDTH-1:0]         rsp_data;
  logic [1:0]                      rsp_resp;
  logic                            rsp_last;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_resp, rsp_last
  );
endinterface

// File: rtl/testdrive_axi4_read_arbiter_rr.sv
// Combinational round-robin picker: first request at or after the pointer wins,
// wrapping back to index 0.
module testdrive_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  int cand;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(pointer) + i) % N;
      if (!valid && req[IW'(cand)]) begin
        valid             = 1'b1;
        grant[IW'(cand)]  = 1'b1;
        index             = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/testdrive_axi4_read_arbiter.sv
// Shares one AXI4 read channel among C_PORTS requesters: round-robin AR grant with
// the port index as ARID, per-port outstanding limit, and RID-routed R beats.
module testdrive_axi4_read_arbiter
  import testdrive_axi4_pkg::*;
#(
  parameter int C_PORTS           = 4,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_THREAD_ID_WIDTH = 4,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst_n,
  testdrive_axi4_read_req_if.slave      req,
  testdrive_axi4_read_arbiter_if.master axi,
  output logic err
);

  localparam int PW = $clog2(C_PORTS);
  localparam int TW = C_THREAD_ID_WIDTH;
  localparam logic [3:0] MAX_CNT = 4'(C_MAX_OUTSTANDING);
  localparam logic [2:0] AR_SIZE = axi_size(C_DATA_WIDTH);

  if (C_THREAD_ID_WIDTH < PW) begin : g_bad_id_width
    $error("C_THREAD_ID_WIDTH too narrow to carry a port index");
  end

  arb_state_t state, state_next;

  logic [C_PORTS-1:0] eligible;
  logic [C_PORTS-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_valid;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      cur;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI4_LEN_WIDTH-1:0] len_q;
  logic [3:0]         cnt [C_PORTS];

  logic [C_PORTS-1:0] req_ready_c;
  logic               take;
  logic               ar_fire;

  logic               rid_ok;
  logic               rready_c;
  logic [C_PORTS-1:0] rsp_valid_c;
  logic [C_PORTS-1:0] inc_vec;
  logic [C_PORTS-1:0] hit_vec;
  logic [C_PORTS-1:0] dec_vec;
  logic [C_PORTS-1:0] zero_vec;
  logic               bad_rid;
  logic               zero_hit;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < C_PORTS; p++) begin
      eligible[p] = req.req_valid[p] && (cnt[p] < MAX_CNT);
    end
  end

  testdrive_rr_arbiter #(.N(C_PORTS)) u_rr (
    .req     (eligible),
    .pointer (ptr),
    .grant   (grant),
    .index   (grant_idx),
    .valid   (grant_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Ready is only offered while idle, so the AR payload stays frozen until ARREADY
  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    take        = 1'b0;
    ar_fire     = 1'b0;
    case (state)
      ARB_IDLE: begin
        req_ready_c = grant;
        if (grant_valid) begin
          take       = 1'b1;
          state_next = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (axi.arready) begin
          ar_fire    = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      ptr    <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      if (take) begin
        cur    <= grant_idx;
        addr_q <= req.req_addr[grant_idx*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        len_q  <= req.req_len[grant_idx*8 +: 8];
      end
      if (ar_fire) ptr <= (cur == PW'(C_PORTS - 1)) ? '0 : cur + 1'b1;
    end
  end

  // Out-of-range RIDs are swallowed so a stray beat never blocks the channel
  always_comb begin
    rid_ok      = 1'b0;
    rready_c    = 1'b1;
    rsp_valid_c = '0;
    for (int p = 0; p < C_PORTS; p++) begin
      if (axi.rid == TW'(p)) begin
        rid_ok         = 1'b1;
        rready_c       = req.rsp_ready[p];
        rsp_valid_c[p] = axi.rvalid;
      end
    end
  end

  always_comb begin
    inc_vec  = '0;
    hit_vec  = '0;
    dec_vec  = '0;
    zero_vec = '0;
    for (int p = 0; p < C_PORTS; p++) begin
      inc_vec[p]  = ar_fire && (cur == PW'(p));
      hit_vec[p]  = rsp_valid_c[p] && rready_c;
      dec_vec[p]  = hit_vec[p] && axi.rlast;
      zero_vec[p] = (cnt[p] == 4'd0);
    end
    bad_rid  = axi.rvalid && !rid_ok;
    zero_hit = |(hit_vec & ~inc_vec & zero_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < C_PORTS; p++) cnt[p] <= '0;
      err <= 1'b0;
    end else begin
      for (int p = 0; p < C_PORTS; p++) begin
        if (inc_vec[p] && !dec_vec[p])
          cnt[p] <= cnt[p] + 1'b1;
        else if (dec_vec[p] && !inc_vec[p] && !zero_vec[p])
          cnt[p] <= cnt[p] - 1'b1;
      end
      if (bad_rid || zero_hit) err <= 1'b1;
    end
  end

  assign req.req_ready = req_ready_c;
  assign req.rsp_valid = rsp_valid_c;
  assign req.rsp_data  = axi.rdata;
  assign req.rsp_resp  = axi.rresp;
  assign req.rsp_last  = axi.rlast;

  assign axi.arvalid = (state == ARB_ADDR);
  assign axi.arid    = TW'(cur);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = AR_SIZE;
  assign axi.arburst = BURST_INCR;
  assign axi.rready  = rready_c;

endmodule

// File: tb/tb_testdrive_axi4_read_arbiter.sv
// Self-checking bench for the AXI4 read arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_testdrive_axi4_read_arbiter;

  localparam int P  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TW = 4;
  localparam int MO = 4;

  logic clk;
  logic rst_n;
  logic err;
  int   checks;
  int   failures;

  testdrive_axi4_read_req_if #(.C_PORTS(P), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) req_bus ();
  testdrive_axi4_read_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_THREAD_ID_WIDTH(TW)) axi_bus ();

  testdrive_axi4_read_arbiter #(
    .C_PORTS(P), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
    .C_THREAD_ID_WIDTH(TW), .C_MAX_OUTSTANDING(MO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_bus),
    .axi   (axi_bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_bus.req_valid = '0;
    req_bus.req_addr  = '0;
    req_bus.req_len   = '0;
    req_bus.rsp_ready = '0;
    axi_bus.arready   = 1'b0;
    axi_bus.rid       = '0;
    axi_bus.rdata     = '0;
    axi_bus.rresp     = '0;
    axi_bus.rlast     = 1'b0;
    axi_bus.rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
    req_bus.req_addr[p*AW +: AW] = addr;
    req_bus.req_len[p*8 +: 8]    = len;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid actual=%0b expected=0", axi_bus.arvalid); end
    checks++; if (axi_bus.arid !== '0) begin failures++; $display("[TB] FAIL reset_arid actual=%0h expected=0", axi_bus.arid); end
    checks++; if (axi_bus.araddr !== '0) begin failures++; $display("[TB] FAIL reset_araddr actual=%0h expected=0", axi_bus.araddr); end
    checks++; if (axi_bus.arlen !== '0) begin failures++; $display("[TB] FAIL reset_arlen actual=%0h expected=0", axi_bus.arlen); end
    checks++; if (req_bus.req_ready !== '0) begin failures++; $display("[TB] FAIL reset_req_ready actual=%b expected=0000", req_bus.req_ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%0b expected=0", err); end
    checks++; if (axi_bus.arsize !== 3'd4) begin failures++; $display("[TB] FAIL arsize actual=%0d expected=4", axi_bus.arsize); end
    checks++; if (axi_bus.arburst !== 2'b01) begin failures++; $display("[TB] FAIL arburst actual=%0d expected=1", axi_bus.arburst); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d;
    set_port(0, 32'h1000, 8'd3);
    req_bus.req_valid = 4'b0001;
    #1;
    checks++; if (req_bus.req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL single_req_ready actual=%b expected=0001", req_bus.req_ready); end
    cycle();
    req_bus.req_valid = '0;
    #1;
    checks++; if (axi_bus.arvalid !== 1'b1) begin failures++; $display("[TB] FAIL single_arvalid actual=%0b expected=1", axi_bus.arvalid); end
    checks++; if (axi_bus.arid !== 4'd0) begin failures++; $display("[TB] FAIL single_arid actual=%0d expected=0", axi_bus.arid); end
    checks++; if (axi_bus.araddr !== 32'h1000) begin failures++; $display("[TB] FAIL single_araddr actual=%0h expected=1000", axi_bus.araddr); end
    checks++; if (axi_bus.arlen !== 8'd3) begin failures++; $display("[TB] FAIL single_arlen actual=%0d expected=3", axi_bus.arlen); end
    checks++; if (req_bus.req_ready !== '0) begin failures++; $display("[TB] FAIL single_ready_in_addr actual=%b expected=0000", req_bus.req_ready); end
    axi_bus.arready = 1'b1;
    cycle();
    axi_bus.arready = 1'b0;
    #1;
    checks++; if (axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_arvalid_drop actual=%0b expected=0", axi_bus.arvalid); end
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      axi_bus.rid       = 4'd0;
      axi_bus.rvalid    = 1'b1;
      axi_bus.rlast     = (b == 3);
      axi_bus.rdata     = d;
      req_bus.rsp_ready = 4'b0001;
      #1;
      checks++; if (req_bus.rsp_valid !== 4'b0001) begin failures++; $display("[TB] FAIL single_rsp_valid beat=%0d actual=%b expected=0001", b, req_bus.rsp_valid); end
      checks++; if (axi_bus.rready !== 1'b1) begin failures++; $display("[TB] FAIL single_rready beat=%0d actual=%0b expected=1", b, axi_bus.rready); end
      checks++; if (req_bus.rsp_data !== d) begin failures++; $display("[TB] FAIL single_rsp_data beat=%0d actual=%0h expected=%0h", b, req_bus.rsp_data, d); end
      checks++; if (req_bus.rsp_last !== (b == 3)) begin failures++; $display("[TB] FAIL single_rsp_last beat=%0d actual=%0b expected=%0b", b, req_bus.rsp_last, (b == 3)); end
      cycle();
    end
    axi_bus.rvalid = 1'b0;
    axi_bus.rlast  = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL single_err actual=%0b expected=0", err); end
  endtask

  task automatic test_round_robin();
    int ptr_m;
    int g;
    bit in_addr;
    logic [AW-1:0] ea;
    logic [7:0] el;
    logic [P-1:0] exp_rr;
    do_reset();
    ptr_m = 0; g = 0; in_addr = 1'b0; ea = '0; el = '0;
    req_bus.req_valid = 4'hF;
    axi_bus.arready   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (!in_addr) begin
        for (int p = 0; p < P; p++) set_port(p, $urandom, 8'($urandom));
        #1;
        exp_rr = '0;
        exp_rr[ptr_m] = 1'b1;
        checks++; if (req_bus.req_ready !== exp_rr) begin failures++; $display("[TB] FAIL rr_grant cyc=%0d actual=%b expected=%b", c, req_bus.req_ready, exp_rr); end
        checks++; if (axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL rr_arvalid_gap cyc=%0d actual=%0b expected=0", c, axi_bus.arvalid); end
        g  = ptr_m;
        ea = req_bus.req_addr[g*AW +: AW];
        el = req_bus.req_len[g*8 +: 8];
        in_addr = 1'b1;
      end else begin
        #1;
        checks++; if (axi_bus.arvalid !== 1'b1) begin failures++; $display("[TB] FAIL rr_arvalid cyc=%0d actual=%0b expected=1", c, axi_bus.arvalid); end
        checks++; if (axi_bus.arid !== 4'(g)) begin failures++; $display("[TB] FAIL rr_arid cyc=%0d actual=%0d expected=%0d", c, axi_bus.arid, g); end
        checks++; if (axi_bus.araddr !== ea || axi_bus.arlen !== el) begin failures++; $display("[TB] FAIL rr_payload cyc=%0d actual=%0h/%0d expected=%0h/%0d", c, axi_bus.araddr, axi_bus.arlen, ea, el); end
        ptr_m   = (g + 1) % P;
        in_addr = 1'b0;
      end
      cycle();
    end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    axi_bus.arready   = 1'b1;
    req_bus.req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_bus.req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL limit_fill k=%0d actual=%b expected=0010", k, req_bus.req_ready); end
      cycle();
      cycle();
    end
    // a port-0 grant moves the pointer onto port 1
    req_bus.req_valid = 4'b0001;
    cycle();
    cycle();
    req_bus.req_valid = 4'b0110;
    #1;
    checks++; if (req_bus.req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL limit_skip actual=%b expected=0100", req_bus.req_ready); end
    cycle();
    req_bus.req_valid = 4'b0010;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_bus.req_ready !== 4'b0000 || axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL limit_stall k=%0d actual=%b/%0b expected=0000/0", k, req_bus.req_ready, axi_bus.arvalid); end
      cycle();
    end
    axi_bus.rid       = 4'd1;
    axi_bus.rvalid    = 1'b1;
    axi_bus.rlast     = 1'b1;
    req_bus.rsp_ready = 4'b0000;
    #1;
    checks++; if (req_bus.rsp_valid !== 4'b0010 || axi_bus.rready !== 1'b0) begin failures++; $display("[TB] FAIL limit_backpressure actual=%b/%0b expected=0010/0", req_bus.rsp_valid, axi_bus.rready); end
    req_bus.rsp_ready = 4'b0010;
    #1;
    checks++; if (axi_bus.rready !== 1'b1) begin failures++; $display("[TB] FAIL limit_rready actual=%0b expected=1", axi_bus.rready); end
    cycle();
    axi_bus.rvalid = 1'b0;
    axi_bus.rlast  = 1'b0;
    #1;
    checks++; if (req_bus.req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL limit_reenable actual=%b expected=0010", req_bus.req_ready); end
  endtask

  task automatic test_ar_stall();
    logic [AW-1:0] a;
    logic [7:0] l;
    do_reset();
    a = $urandom;
    l = 8'($urandom);
    set_port(3, a, l);
    req_bus.req_valid = 4'b1000;
    #1;
    checks++; if (req_bus.req_ready !== 4'b1000) begin failures++; $display("[TB] FAIL stall_grant actual=%b expected=1000", req_bus.req_ready); end
    cycle();
    req_bus.req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < P; p++) set_port(p, $urandom, 8'($urandom));
      #1;
      checks++; if (axi_bus.arvalid !== 1'b1 || axi_bus.arid !== 4'd3) begin failures++; $display("[TB] FAIL stall_valid_id cyc=%0d actual=%0b/%0d expected=1/3", c, axi_bus.arvalid, axi_bus.arid); end
      checks++; if (axi_bus.araddr !== a || axi_bus.arlen !== l) begin failures++; $display("[TB] FAIL stall_payload cyc=%0d actual=%0h/%0d expected=%0h/%0d", c, axi_bus.araddr, axi_bus.arlen, a, l); end
      checks++; if (req_bus.req_ready !== '0) begin failures++; $display("[TB] FAIL stall_req_ready cyc=%0d actual=%b expected=0000", c, req_bus.req_ready); end
      cycle();
    end
    axi_bus.arready = 1'b1;
    cycle();
    axi_bus.arready = 1'b0;
    checks++; if (axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release actual=%0b expected=0", axi_bus.arvalid); end
    checks++; if (req_bus.req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL stall_wrap_ptr actual=%b expected=0001", req_bus.req_ready); end
  endtask

  task automatic test_bad_rid();
    do_reset();
    axi_bus.rid       = 4'd5;
    axi_bus.rvalid    = 1'b1;
    req_bus.rsp_ready = 4'h0;
    #1;
    checks++; if (axi_bus.rready !== 1'b1) begin failures++; $display("[TB] FAIL badrid_rready actual=%0b expected=1", axi_bus.rready); end
    checks++; if (req_bus.rsp_valid !== '0) begin failures++; $display("[TB] FAIL badrid_rsp_valid actual=%b expected=0000", req_bus.rsp_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL badrid_err_early actual=%0b expected=0", err); end
    cycle();
    axi_bus.rvalid = 1'b0;
    axi_bus.rid    = '0;
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL badrid_err_set actual=%0b expected=1", err); end
    repeat (5) cycle();
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL badrid_err_sticky actual=%0b expected=1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL badrid_err_clear actual=%0b expected=0", err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_bus.req_valid = 4'b0001;
    axi_bus.arready   = 1'b1;
    repeat (4) cycle();
    axi_bus.arready = 1'b0;
    cycle();
    checks++; if (axi_bus.arvalid !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_addr actual=%0b expected=1", axi_bus.arvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_async actual=%0b expected=0", axi_bus.arvalid); end
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_err actual=%0b expected=0", err); end
    req_bus.req_valid = 4'hF;
    #1;
    checks++; if (req_bus.req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_ptr actual=%b expected=0001", req_bus.req_ready); end
    req_bus.req_valid = 4'b0001;
    axi_bus.arready   = 1'b1;
    for (int k = 0; k < MO; k++) begin
      #1;
      checks++; if (req_bus.req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_cnt k=%0d actual=%b expected=0001", k, req_bus.req_ready); end
      cycle();
      cycle();
    end
    checks++; if (req_bus.req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_limit actual=%b expected=0000", req_bus.req_ready); end
  endtask

  task automatic test_random();
    int outst [P];
    int pend_id [$];
    int pend_len [$];
    int ptr_m, g_m, exp_w, q, act_id, act_len, beat;
    bit in_addr, act;
    logic [AW-1:0] ea;
    logic [7:0] el;
    logic [P-1:0] exp_rr, exp_rv;
    logic exp_rdy;
    do_reset();
    for (int p = 0; p < P; p++) outst[p] = 0;
    ptr_m = 0; g_m = 0; in_addr = 1'b0; act = 1'b0;
    act_id = 0; act_len = 0; beat = 0; ea = '0; el = '0;
    for (int c = 0; c < 600; c++) begin
      req_bus.req_valid = 4'($urandom);
      if (!in_addr)
        for (int p = 0; p < P; p++) set_port(p, $urandom, 8'($urandom_range(0, 3)));
      axi_bus.arready   = ($urandom_range(0, 2) != 0);
      req_bus.rsp_ready = 4'($urandom);
      if (!act && pend_id.size() > 0 && $urandom_range(0, 1) == 1) begin
        act     = 1'b1;
        act_id  = pend_id.pop_front();
        act_len = pend_len.pop_front();
        beat    = 0;
      end
      axi_bus.rvalid = act;
      axi_bus.rid    = act ? 4'(act_id) : 4'd0;
      axi_bus.rlast  = act && (beat == act_len);
      axi_bus.rdata  = {$urandom, $urandom, $urandom, $urandom};
      axi_bus.rresp  = 2'($urandom);
      #1;
      if (!in_addr) begin
        exp_w = -1;
        for (int k = 0; k < P; k++) begin
          q = (ptr_m + k) % P;
          if (exp_w < 0 && req_bus.req_valid[q] && outst[q] < MO) exp_w = q;
        end
        exp_rr = '0;
        if (exp_w >= 0) exp_rr[exp_w] = 1'b1;
        checks++; if (req_bus.req_ready !== exp_rr || axi_bus.arvalid !== 1'b0) begin failures++; $display("[TB] FAIL rand_idle cyc=%0d actual=%b/%0b expected=%b/0", c, req_bus.req_ready, axi_bus.arvalid, exp_rr); end
      end else begin
        exp_w = -1;
        checks++; if (axi_bus.arvalid !== 1'b1 || axi_bus.arid !== 4'(g_m) || axi_bus.araddr !== ea || axi_bus.arlen !== el || req_bus.req_ready !== '0) begin
          failures++; $display("[TB] FAIL rand_addr cyc=%0d actual=%0b/%0d/%0h/%0d expected=1/%0d/%0h/%0d", c, axi_bus.arvalid, axi_bus.arid, axi_bus.araddr, axi_bus.arlen, g_m, ea, el);
        end
      end
      exp_rv = '0;
      if (act) exp_rv[act_id] = 1'b1;
      exp_rdy = req_bus.rsp_ready[act ? act_id : 0];
      checks++; if (req_bus.rsp_valid !== exp_rv || axi_bus.rready !== exp_rdy) begin failures++; $display("[TB] FAIL rand_route cyc=%0d actual=%b/%0b expected=%b/%0b", c, req_bus.rsp_valid, axi_bus.rready, exp_rv, exp_rdy); end
      checks++; if (req_bus.rsp_data !== axi_bus.rdata || req_bus.rsp_resp !== axi_bus.rresp || req_bus.rsp_last !== (act && beat == act_len)) begin failures++; $display("[TB] FAIL rand_passthru cyc=%0d last actual=%0b", c, req_bus.rsp_last); end
      if (act && req_bus.rsp_ready[act_id]) begin
        if (beat == act_len) begin
          outst[act_id]--;
          act = 1'b0;
        end else begin
          beat++;
        end
      end
      if (!in_addr) begin
        if (exp_w >= 0) begin
          in_addr = 1'b1;
          g_m = exp_w;
          ea  = req_bus.req_addr[g_m*AW +: AW];
          el  = req_bus.req_len[g_m*8 +: 8];
        end
      end else if (axi_bus.arready) begin
        in_addr = 1'b0;
        outst[g_m]++;
        ptr_m = (g_m + 1) % P;
        pend_id.push_back(g_m);
        pend_len.push_back(int'(el));
      end
      cycle();
    end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rand_err actual=%0b expected=0", err); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_outstanding_limit();
    test_ar_stall();
    test_bad_rid();
    test_reset_mid_burst();
    test_random();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
